// File: rtl/mem_map_pkg.sv
// Shared definitions for the processor data-port responder.
//  - byte_t            : one byte of RAM or MMIO data
//  - OFF_*             : MMIO register offsets relative to the MMIO base address
//  - ST_*              : bit positions inside the STATUS register
//  - status_byte()     : packs the STATUS register image
package mem_map_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [31:0] OFF_TX_DATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFF_RX_DATA = 32'h0000_0008;
  localparam logic [31:0] OFF_RX_ACK  = 32'h0000_000C;
  localparam logic [31:0] OFF_CYCLE   = 32'h0000_0010;
  localparam logic [31:0] CYCLE_BYTES = 32'd4;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_RX_FULL  = 3;

  function automatic byte_t status_byte(input logic rx_full, input logic overflow,
                                        input logic tx_empty, input logic tx_full);
    byte_t s;
    s              = '0;
    s[ST_RX_FULL]  = rx_full;
    s[ST_OVERFLOW] = overflow;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_TX_FULL]  = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered storage and no fall-through.
// Ports:
//  clk, reset   clock and synchronous active-high reset (pointers/count only)
//  push_i       write request; accepted when not full, or when a pop happens this cycle
//  data_i       byte written on an accepted push
//  pop_i        remove head; ignored while empty
//  head_o       current head byte (meaningless while empty)
//  full_o       count == DEPTH
//  empty_o      count == 0
//  count_o      number of stored bytes, 0..DEPTH
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_acc, push_acc;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // take a push when it is also being drained.
  assign pop_acc  = pop_i & ~empty_o;
  assign push_acc = push_i & (~full_o | pop_acc);

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the single-cycle processor data port.
// Serves a byte RAM at 0..RAM_DEPTH-1 and an MMIO window at MMIO_BASE holding
// a TX FIFO, an RX holding register and a free-running cycle counter snapshot.
// Ports:
//  clk, reset          clock, synchronous active-high reset (RAM is not cleared)
//  MemWrite            write strobe, sampled at posedge
//  ALUResult           byte address (full 32-bit decode, no aliasing)
//  WriteData           write data, byte in [7:0]; bit 2 also used by STATUS write
//  ReadData            combinational read data for ALUResult, no side effects
//  tx_data/tx_valid    head of TX FIFO / FIFO non-empty
//  tx_ready            peripheral takes head when tx_valid & tx_ready
//  rx_data/rx_valid    byte offered by input peripheral
//  rx_ready            high while the RX holding register is empty
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int          RAM_DEPTH = 256,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [7:0]  ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_DEPTH);
  localparam int          TX_CW     = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_DEPTH);

  logic [7:0]  ram_q [RAM_DEPTH];
  logic        overflow_q, overflow_d;
  logic        rx_full_q,  rx_full_d;
  logic [7:0]  rx_hold_q,  rx_hold_d;
  logic [31:0] cycle_q;
  logic [31:0] snapshot_q, snapshot_d;

  logic [31:0] mmio_off, cyc_off;
  logic        hit_ram, hit_tx, hit_status, hit_rx_data, hit_rx_ack, hit_cycle, hit_snap;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_capture, rx_ack, ovf_set, ovf_clr;
  logic [TX_CW-1:0] tx_count;
  logic        unused_bits;

  // Address decode
  assign mmio_off    = ALUResult - MMIO_BASE;
  assign cyc_off     = mmio_off - OFF_CYCLE;
  assign hit_ram     = (ALUResult < RAM_LIMIT);
  assign hit_tx      = (ALUResult == MMIO_BASE + OFF_TX_DATA);
  assign hit_status  = (ALUResult == MMIO_BASE + OFF_STATUS);
  assign hit_rx_data = (ALUResult == MMIO_BASE + OFF_RX_DATA);
  assign hit_rx_ack  = (ALUResult == MMIO_BASE + OFF_RX_ACK);
  assign hit_snap    = (ALUResult == MMIO_BASE + OFF_CYCLE);
  // The base check stops addresses below MMIO_BASE from wrapping into the window.
  assign hit_cycle   = (ALUResult >= MMIO_BASE) && (cyc_off < CYCLE_BYTES) &&
                       (mmio_off >= OFF_CYCLE);

  assign unused_bits = ^{WriteData[31:8], cyc_off[31:2]};

  // TX FIFO
  assign tx_push  = MemWrite & hit_tx;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = (tx_count != '0);

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .data_i  (WriteData[7:0]),
    .pop_i   (tx_pop),
    .head_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign rx_ready   = ~rx_full_q;
  assign rx_capture = rx_valid & ~rx_full_q;
  assign rx_ack     = MemWrite & hit_rx_ack;
  // A push onto a full FIFO is lost only when no pop frees a slot this cycle.
  assign ovf_set    = tx_push & tx_full & ~tx_pop;
  assign ovf_clr    = MemWrite & hit_status & WriteData[ST_OVERFLOW];

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;

    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    if (rx_capture) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end else if (rx_ack) begin
      rx_full_d = 1'b0;
    end

    snapshot_d = snapshot_q;
    if (MemWrite && hit_snap) snapshot_d = cycle_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_hold_q  <= '0;
      cycle_q    <= '0;
      snapshot_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      rx_full_q  <= rx_full_d;
      rx_hold_q  <= rx_hold_d;
      cycle_q    <= cycle_q + 32'd1;
      snapshot_q <= snapshot_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (MemWrite && hit_ram) ram_q[ALUResult[RAM_AW-1:0]] <= WriteData[7:0];
  end

  // Read mux
  always_comb begin
    ReadData = '0;
    if (hit_ram)          ReadData = ram_q[ALUResult[RAM_AW-1:0]];
    else if (hit_status)  ReadData = status_byte(rx_full_q, overflow_q, tx_empty, tx_full);
    else if (hit_rx_data) ReadData = rx_hold_q;
    else if (hit_cycle)   ReadData = snapshot_q[{cyc_off[1:0], 3'b000} +: 8];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int          RAM_DEPTH = 256;
  localparam int          TX_DEPTH  = 8;
  localparam logic [31:0] BASE      = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [7:0]  ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  data_mem_responder #(
    .RAM_DEPTH (RAM_DEPTH),
    .TX_DEPTH  (TX_DEPTH),
    .MMIO_BASE (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_ram [RAM_DEPTH];
  bit          m_known [RAM_DEPTH];
  logic [7:0]  m_txq [$];
  bit          m_ovf, m_rxf, m_init;
  logic [7:0]  m_rxh;
  logic [31:0] m_cyc, m_snap;

  typedef struct {
    bit          chk;
    bit          rd_chk;
    logic [7:0]  rd_exp;
    bit          rxr_exp;
    bit          txv_exp;
    int          cexp;
    logic [31:0] addr;
  } rec_t;

  rec_t       exp_q [$];
  logic [7:0] tx_sb [$];
  int         n_pass  = 0;
  int         n_total = 0;

  function automatic logic [7:0] model_read(input logic [31:0] a, output bit known);
    logic [31:0] o;
    known = 1'b1;
    if (a < RAM_DEPTH) begin
      known = m_known[a];
      return m_ram[a];
    end
    o = a - BASE;
    case (o)
      32'h04: return {4'b0, m_rxf, m_ovf, m_txq.size() == 0, m_txq.size() == TX_DEPTH};
      32'h08: return m_rxh;
      32'h10: return m_snap[7:0];
      32'h11: return m_snap[15:8];
      32'h12: return m_snap[23:16];
      32'h13: return m_snap[31:24];
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s addr=%h got=%h want=%h", nm, a, act, exp);
  endtask

  // One clock of stimulus: drive, record what must be observed this cycle,
  // then advance the model to the state after the coming edge.
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input bit txr, input bit rxv, input logic [7:0] rxd,
                      input bit rst, input int cexp = -1);
    rec_t r;
    bit   kn, pop, acc, set;
    @(posedge clk);
    #1;
    MemWrite  = we;
    ALUResult = a;
    WriteData = wd;
    tx_ready  = txr;
    rx_valid  = rxv;
    rx_data   = rxd;
    reset     = rst;

    r.chk     = m_init;
    r.rd_exp  = model_read(a, kn);
    r.rd_chk  = m_init && kn;
    r.rxr_exp = !m_rxf;
    r.txv_exp = (m_txq.size() != 0);
    r.cexp    = cexp;
    r.addr    = a;
    exp_q.push_back(r);

    if (we && a < RAM_DEPTH) begin
      m_ram[a]   = wd[7:0];
      m_known[a] = 1'b1;
    end
    if (rst) begin
      m_txq.delete();
      tx_sb.delete();
      m_ovf  = 0;
      m_rxf  = 0;
      m_rxh  = 8'h00;
      m_cyc  = 0;
      m_snap = 0;
      m_init = 1;
    end else begin
      pop = txr && (m_txq.size() != 0);
      acc = (m_txq.size() < TX_DEPTH) || pop;
      set = 0;
      if (pop) void'(m_txq.pop_front());
      if (we && a == BASE) begin
        if (acc) begin
          m_txq.push_back(wd[7:0]);
          tx_sb.push_back(wd[7:0]);
        end else begin
          set = 1;
        end
      end
      if (set) m_ovf = 1;
      else if (we && a == BASE + 32'h4 && wd[2]) m_ovf = 0;
      if (rxv && !m_rxf) begin
        m_rxf = 1;
        m_rxh = rxd;
      end else if (we && a == BASE + 32'hC) begin
        m_rxf = 0;
      end
      if (we && a == BASE + 32'h10) m_snap = m_cyc;
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1, a, d, 0, 0, 8'h00, 0);
  endtask

  task automatic rd(input logic [31:0] a, input int c);
    step(0, a, 0, 0, 0, 8'h00, 0, c);
  endtask

  // Monitor: compares each cycle's record and every TX handshake.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        if (r.chk) begin
          check("rx_ready", r.addr, 32'(rx_ready), 32'(r.rxr_exp));
          check("tx_valid", r.addr, 32'(tx_valid), 32'(r.txv_exp));
          if (r.rd_chk) check("read_model", r.addr, 32'(ReadData), 32'(r.rd_exp));
          if (r.cexp >= 0) check("read_const", r.addr, 32'(ReadData), r.cexp);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (tx_sb.size() == 0) begin
          n_total++;
          $display("FAIL tx_extra got=%h want=none", tx_data);
        end else begin
          check("tx_data", BASE, 32'(tx_data), 32'(tx_sb.pop_front()));
        end
      end
    end
  end

  initial begin
    int k;
    logic [31:0] a;
    bit rst_r;
    MemWrite = 0; ALUResult = 0; WriteData = 0; tx_ready = 0;
    rx_valid = 0; rx_data = 0; reset = 1;
    m_init = 0;

    repeat (3) step(0, 0, 0, 0, 0, 8'h00, 1);

    // RAM
    wr(32'h10, 32'hA5);
    wr(32'hFF, 32'h3C);
    rd(32'h10, 'hA5);
    rd(32'hFF, 'h3C);
    rd(32'h100, 'h00);

    // TX fill, overflow, ordered drain
    for (int i = 1; i <= 8; i++) wr(BASE, i);
    rd(BASE + 4, 'h01);
    wr(BASE, 32'h09);
    rd(BASE + 4, 'h05);
    repeat (8) step(0, BASE + 4, 0, 1, 0, 8'h00, 0);
    rd(BASE + 4, 'h06);
    wr(BASE + 4, 32'h4);
    rd(BASE + 4, 'h02);

    // Full FIFO with pop and push together
    for (int i = 0; i < 8; i++) wr(BASE, 32'h11 + i);
    step(1, BASE, 32'h77, 1, 0, 8'h00, 0);
    rd(BASE + 4, 'h01);
    repeat (8) step(0, BASE + 4, 0, 1, 0, 8'h00, 0);
    rd(BASE + 4, 'h02);

    // RX capture, hold, ack, second byte
    step(0, BASE + 4, 0, 0, 1, 8'h5A, 0);
    step(0, BASE + 8, 0, 0, 1, 8'h6B, 0, 'h5A);
    step(0, BASE + 4, 0, 0, 1, 8'h6B, 0, 'h0A);
    step(1, BASE + 12, 0, 0, 1, 8'h6B, 0);
    step(0, BASE + 8, 0, 0, 1, 8'h6B, 0, 'h5A);
    rd(BASE + 8, 'h6B);
    wr(BASE + 12, 32'h0);
    rd(BASE + 4, 'h02);

    // Cycle snapshot after reset release: write happens at cycle 5
    repeat (2) step(0, 0, 0, 0, 0, 8'h00, 1);
    repeat (5) rd(BASE + 32'h20, 'h00);
    wr(BASE + 32'h10, 32'h0);
    rd(BASE + 32'h10, 'h05);
    rd(BASE + 32'h11, 'h00);
    rd(BASE + 32'h12, 'h00);
    rd(BASE + 32'h13, 'h00);

    // Reset in the middle of traffic
    wr(32'h20, 32'hC3);
    for (int i = 0; i < 9; i++) wr(BASE, 32'h30 + i);
    repeat (5) step(0, BASE + 4, 0, 1, 0, 8'h00, 0);
    step(0, BASE + 4, 0, 0, 1, 8'h44, 0);
    rd(BASE + 4, 'h0C);
    step(0, 0, 0, 0, 0, 8'h00, 1);
    rd(BASE + 4, 'h02);
    rd(32'h20, 'hC3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: a = 32'($urandom_range(0, RAM_DEPTH - 1));
        3:       a = BASE;
        4:       a = BASE + 4;
        5:       a = BASE + 8;
        6:       a = BASE + 12;
        7:       a = BASE + 32'($urandom_range(16, 19));
        8:       a = BASE + 32'($urandom_range(0, 31));
        default: a = $urandom;
      endcase
      rst_r = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 2) == 0, a, $urandom, rst_r ? 1'b0 : 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom), rst_r);
    end

    // Drain and close out
    repeat (TX_DEPTH + 2) step(0, BASE + 4, 0, 1, 0, 8'h00, 0);
    rd(BASE + 4, -1);
    repeat (3) @(negedge clk);
    check("tx_leftover", BASE, 32'(tx_sb.size()), 32'd0);
    check("exp_leftover", BASE, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
